// File: rtl/gb_apu_pkg.sv
// Shared APU types and constants: step index type, per-step tick masks, default prescale.
// The masks are indexed by the step that is about to execute.
package gb_apu_pkg;

  typedef logic [2:0] fs_step_t;

  localparam logic [7:0] FS_LEN_MASK   = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_MASK = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_MASK   = 8'b1000_0000;

  localparam int FS_PRESCALE_DEFAULT = 8192;

endpackage

// File: rtl/gb_framesequencer_if.sv
// Control and tick bundle between the APU core and its frame sequencer.
// The master side drives power and the DIV source; the slave side returns ticks and step.
interface gb_framesequencer_if;
  import gb_apu_pkg::*;

  logic     apu_en;
  logic     div_bit;
  logic     length_tick;
  logic     sweep_tick;
  logic     env_tick;
  fs_step_t step;
  logic     len_skip;

  modport master (
    output apu_en,
    output div_bit,
    input  length_tick,
    input  sweep_tick,
    input  env_tick,
    input  step,
    input  len_skip
  );

  modport slave (
    input  apu_en,
    input  div_bit,
    output length_tick,
    output sweep_tick,
    output env_tick,
    output step,
    output len_skip
  );

endinterface

// File: rtl/gb_fs_base_tick.sv
// One-cycle 512 Hz base event source for the frame sequencer.
// FS_EXT_DIV_EN selects a falling-edge detector on div_bit instead of the internal prescaler.
module gb_fs_base_tick #(
  parameter int PRESCALE = 8192,
  parameter int PS_WIDTH = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic apu_en,
  input  logic div_bit,
  output logic base_event
);

`ifdef FS_EXT_DIV_EN
  logic div_q;

  // Keeps tracking div_bit while powered down so enabling never sees a stale edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_bit;
    end
  end

  assign base_event = apu_en & div_q & ~div_bit;
`else
  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] ps_count;
  logic                ps_last;
  logic                unused_div_bit;

  assign ps_last        = (ps_count == PS_LAST);
  assign unused_div_bit = div_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_count <= '0;
    end else if (!apu_en || ps_last) begin
      ps_count <= '0;
    end else begin
      ps_count <= ps_count + 1'b1;
    end
  end

  assign base_event = apu_en & ps_last;
`endif

endmodule

// File: rtl/gb_framesequencer.sv
// APU frame sequencer: turns the base event into length/sweep/envelope ticks over an 8-step cycle.
// Build option FS_EXT_DIV_EN takes the base event from div_bit edges instead of a prescaler.
module gb_framesequencer
  import gb_apu_pkg::*;
#(
  parameter int PRESCALE = FS_PRESCALE_DEFAULT,
  parameter int PS_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  gb_framesequencer_if.slave   fs
);

  fs_step_t   step_q;
  fs_step_t   step_d;
  logic [2:0] ticks_q;
  logic [2:0] ticks_d;
  logic       base_event;

  gb_fs_base_tick #(
    .PRESCALE (PRESCALE),
    .PS_WIDTH (PS_WIDTH)
  ) u_base_tick (
    .clk        (clk),
    .reset      (reset),
    .apu_en     (fs.apu_en),
    .div_bit    (fs.div_bit),
    .base_event (base_event)
  );

  // Power-down wins over a coincident base event; ticks decode the step being executed.
  always_comb begin
    step_d  = step_q;
    ticks_d = '0;
    if (!fs.apu_en) begin
      step_d = '0;
    end else if (base_event) begin
      ticks_d = {FS_ENV_MASK[step_q], FS_SWEEP_MASK[step_q], FS_LEN_MASK[step_q]};
      step_d  = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q  <= '0;
      ticks_q <= '0;
    end else begin
      step_q  <= step_d;
      ticks_q <= ticks_d;
    end
  end

  assign fs.length_tick = ticks_q[0];
  assign fs.sweep_tick  = ticks_q[1];
  assign fs.env_tick    = ticks_q[2];
  assign fs.step        = step_q;
  assign fs.len_skip    = step_q[0];

endmodule

// File: tb/tb_gb_framesequencer.sv
// Directed bench for gb_framesequencer with PRESCALE=4; FS_EXT_DIV_EN builds run the div_bit edge tests.
// Tick vectors are packed {env, sweep, length}.
module tb_gb_framesequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [2:0] exp_ticks [8];

  gb_framesequencer_if fs_if ();

  gb_framesequencer #(
    .PRESCALE (4),
    .PS_WIDTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (fs_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic apu_en, input logic div_bit);
    fs_if.apu_en  = apu_en;
    fs_if.div_bit = div_bit;
  endtask

  task automatic runCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [2:0] exp_step, input logic [2:0] exp_tk);
    checkOutput({tag, "_step"}, {5'd0, fs_if.step}, {5'd0, exp_step});
    checkOutput({tag, "_ticks"}, {5'd0, fs_if.env_tick, fs_if.sweep_tick, fs_if.length_tick}, {5'd0, exp_tk});
    checkOutput({tag, "_lenskip"}, {7'd0, fs_if.len_skip}, {7'd0, exp_step[0]});
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b1);
    reset = 1'b0;
    runCycle();
    reset = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_ticks[0] = 3'b001;
    exp_ticks[1] = 3'b000;
    exp_ticks[2] = 3'b011;
    exp_ticks[3] = 3'b000;
    exp_ticks[4] = 3'b001;
    exp_ticks[5] = 3'b000;
    exp_ticks[6] = 3'b011;
    exp_ticks[7] = 3'b100;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1);

`ifndef FS_EXT_DIV_EN
    repeat (2) runCycle();
    checkState("rst_hold", 3'd0, 3'b000);
    reset = 1'b1;
    runCycle();
    checkState("rst_release", 3'd0, 3'b000);

    // Ten base events: three idle cycles then one tick cycle each.
    resetDut();
    for (int k = 0; k < 10; k++) begin
      repeat (3) begin
        runCycle();
        checkState($sformatf("ev%0d_idle", k), 3'(k % 8), 3'b000);
      end
      runCycle();
      checkState($sformatf("ev%0d_tick", k), 3'((k + 1) % 8), exp_ticks[k % 8]);
    end

    // Step 2 executes next; kill it with an async reset while the tick is high.
    repeat (4) runCycle();
    checkState("pre_async", 3'd3, 3'b011);
    reset = 1'b0;
    #1;
    checkState("async_rst", 3'd0, 3'b000);
    reset = 1'b1;

    resetDut();
    repeat (22) runCycle();
    checkState("pre_dis", 3'd5, 3'b000);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      runCycle();
      checkState($sformatf("dis%0d", i), 3'd0, 3'b000);
    end
    applyStimulus(1'b1, 1'b1);
    repeat (3) begin
      runCycle();
      checkState("reen_idle", 3'd0, 3'b000);
    end
    runCycle();
    checkState("reen_tick", 3'd1, 3'b001);

    // Disable lands in the cycle the prescaler sits at its last count.
    resetDut();
    repeat (3) runCycle();
    applyStimulus(1'b0, 1'b1);
    runCycle();
    checkState("coll", 3'd0, 3'b000);
    runCycle();
    checkState("coll_after", 3'd0, 3'b000);
`else
    resetDut();
    for (int k = 0; k < 8; k++) begin
      runCycle();
      checkState($sformatf("ext%0d_rise", k), 3'(k), 3'b000);
      applyStimulus(1'b1, 1'b0);
      runCycle();
      checkState($sformatf("ext%0d_fall", k), 3'((k + 1) % 8), exp_ticks[k]);
      applyStimulus(1'b1, 1'b1);
    end
    runCycle();
    checkState("ext_rise_only", 3'd0, 3'b000);

    applyStimulus(1'b0, 1'b1);
    runCycle();
    checkState("ext_off_hi", 3'd0, 3'b000);
    applyStimulus(1'b0, 1'b0);
    runCycle();
    checkState("ext_off_fall", 3'd0, 3'b000);
    applyStimulus(1'b0, 1'b1);
    runCycle();
    applyStimulus(1'b1, 1'b1);
    runCycle();
    checkState("ext_en_hi", 3'd0, 3'b000);
    applyStimulus(1'b1, 1'b0);
    runCycle();
    checkState("ext_en_fall", 3'd1, 3'b001);
    runCycle();
    checkState("ext_en_after", 3'd1, 3'b000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_framesequencer.md
Name: gb_frameSequencer

Overview:
- Frame sequencer for the APU.
- Divides a 512 Hz base tick into the per-step clocks used by the channel units:
  - 256 Hz length-counter clock, which drives each length function's clk_length_ctr
  - 128 Hz sweep clock
  - 64 Hz envelope clock
- One instance per APU, shared by all four channels.
- Exports its step position so channels can apply the "extra length clock on trigger" rule.

Parameters:
- PRESCALE, 8192, system clocks per 512 Hz base tick. Internal prescaler only; 4.194304 MHz / 512.
- PS_WIDTH, 13, prescaler counter width. Must satisfy 2**PS_WIDTH >= PRESCALE.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- apu_en  input  1  APU master power (NR52 bit 7). Low holds the sequencer idle.
- div_bit  input  1  DIV-APU source bit. Used only when FS_EXT_DIV_EN is defined; otherwise ignored.
- length_tick  output  1  one-cycle pulse on steps 0, 2, 4, 6
- sweep_tick  output  1  one-cycle pulse on steps 2, 6
- env_tick  output  1  one-cycle pulse on step 7
- step  output  3  index of the next step to execute
- len_skip  output  1  high when the next step does not clock length (step[0]==1)

Behaviour:
- Reset (reset low, asynchronous):
  - step=0, prescaler=0
  - all tick outputs 0
  - internal div sample register = 0
- Base event, internal mode:
  - Prescaler counts 0..PRESCALE-1 while apu_en=1.
  - A base event occurs in the cycle where the count equals PRESCALE-1; the count then wraps to 0.
- Step sequencing on a base event:
  - Tick outputs are registered and asserted in the cycle after the base event, decoded from the pre-increment step value.
  - step increments mod 8 (7 -> 0 wraps) on the same edge.
- Output timing:
  - Each tick is exactly one clk cycle wide.
  - Ticks are 0 in every cycle without a base event.
- apu_en low (synchronous to clk):
  - step forced to 0 and prescaler forced to 0 every cycle.
  - No ticks; any tick already registered still completes its single cycle.
  - After apu_en rises, the first base event executes step 0:
    - internal mode: PRESCALE cycles after the rise
    - external mode: on the first qualifying edge
- apu_en falling on the same cycle as a base event: disable wins; no step advance, no tick.
- Reset mid-operation: all state returns to reset values immediately, with no residual pulse.
- len_skip equals step[0], combinational from the step register.
- Step function table:
  - step 0: length
  - step 1: none
  - step 2: length + sweep
  - step 3: none
  - step 4: length
  - step 5: none
  - step 6: length + sweep
  - step 7: envelope

Optional Feature:
- FS_EXT_DIV_EN defined:
  - Internal prescaler is removed.
  - div_bit is sampled into a register each cycle.
  - A base event is a detected falling edge: sample=1 and current div_bit=0.
  - While apu_en=0 the sample register still tracks div_bit, so no spurious edge occurs at enable.
  - PRESCALE and PS_WIDTH are unused.
- FS_EXT_DIV_EN undefined: internal prescaler as described above; div_bit unconnected internally.

Decomposition:
- Package gb_apu_pkg:
  - typedef fs_step_t (logic [2:0])
  - localparams FS_LEN_MASK=8'b0101_0101, FS_SWEEP_MASK=8'b0100_0100, FS_ENV_MASK=8'b1000_0000, indexed by step
  - localparam FS_PRESCALE_DEFAULT=8192
- Sub-module gb_fsBaseTick: produces the one-cycle base event from either the prescaler or the div_bit edge detector, selected by the macro. Step counter and tick decode stay in gb_frameSequencer.

Test Plan:
- Reset check, PRESCALE=4: reset low for 2 cycles with apu_en=1 -> step=0, all ticks 0, len_skip=0 during and one cycle after release.
- Full cycle, PRESCALE=4, apu_en=1, run 32 cycles:
  - length_tick pulses on base events 1, 3, 5, 7; sweep_tick on events 3, 7; env_tick on event 8
  - each pulse 1 cycle wide, 4 cycles apart per event
  - step sequence 0..7 then 0
- Wrap and len_skip: run 10 base events -> step reads 2 after the 10th event; len_skip toggles 0/1 each event.
- Disable mid-sequence: drop apu_en when step=5 -> step=0 next cycle, no ticks. Re-raise apu_en -> first tick after exactly 4 cycles is length_tick (step 0).
- Disable/event collision: apu_en falls on the cycle the prescaler equals 3 -> no tick emitted, step=0.
- FS_EXT_DIV_EN build:
  - toggle div_bit 1->0 eight times -> ticks follow the step table
  - 0->1 transitions produce nothing
  - div_bit held at 1 across an apu_en rise followed by a falling edge -> exactly one length_tick
